// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W = 32;

  // Index counter width; at least one bit even for a single-slice build.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_csa.sv
// 32-bit carry-select adder: 4-bit blocks compute both carry-in cases and the
// incoming carry picks one. The overflow output covers only this 32-bit slice.
module add_seq_ctrl_csa
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               of
);

  localparam int BLK_W = 4;
  localparam int NBLK  = SLICE_W / BLK_W;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      logic [BLK_W:0] sum_c0;
      logic [BLK_W:0] sum_c1;

      assign sum_c0 = {1'b0, a[gi*BLK_W +: BLK_W]} + {1'b0, b[gi*BLK_W +: BLK_W]};
      assign sum_c1 = sum_c0 + {{BLK_W{1'b0}}, 1'b1};

      assign sum[gi*BLK_W +: BLK_W] = carry[gi] ? sum_c1[BLK_W-1:0] : sum_c0[BLK_W-1:0];
      assign carry[gi+1]            = carry[gi] ? sum_c1[BLK_W]     : sum_c0[BLK_W];
    end
  endgenerate

  assign cout = carry[NBLK];
  assign of   = (a[SLICE_W-1] == b[SLICE_W-1]) && (sum[SLICE_W-1] != a[SLICE_W-1]);

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add sequencer: one shared 32-bit adder, one slice per cycle,
// low slice first. Define ADD_SEQ_SUB_EN to add the in_sub subtract port.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_of
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic               carry_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       sum_reg;
  logic               cout_reg;
  logic               of_reg;

  logic [SLICE_W-1:0] csa_a;
  logic [SLICE_W-1:0] csa_b;
  logic [SLICE_W-1:0] csa_sum;
  logic               csa_cout;
  logic               csa_of_unused;
  logic               last_slice;

  assign csa_a      = a_reg[SLICE_W*idx_reg +: SLICE_W];
  assign csa_b      = b_reg[SLICE_W*idx_reg +: SLICE_W];
  assign last_slice = (idx_reg == IDX_LAST);

  add_seq_ctrl_csa u_csa (
    .a    (csa_a),
    .b    (csa_b),
    .cin  (carry_reg),
    .sum  (csa_sum),
    .cout (csa_cout),
    .of   (csa_of_unused)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      of_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            idx_reg <= '0;
`ifdef ADD_SEQ_SUB_EN
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub ? 1'b1 : in_cin;
`else
            b_reg     <= in_b;
            carry_reg <= in_cin;
`endif
          end
        end
        RUN: begin
          sum_reg[SLICE_W*idx_reg +: SLICE_W] <= csa_sum;
          carry_reg <= csa_cout;
          if (last_slice) begin
            // Top slice is on the adder now, so full-width overflow is visible here.
            cout_reg <= csa_cout;
            of_reg   <= (a_reg[W-1] == b_reg[W-1]) && (csa_sum[SLICE_W-1] != a_reg[W-1]);
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_of    = of_reg;

endmodule
